// File: rtl/jailbreak_speech_decimator.sv
// Box-car decimator for the VLM5030 speech stream: averages 2^LOG2_RATIO samples taken
// on a DIV-clock tick grid and offers each result to the mixer over valid/ready.
module jailbreak_speech_decimator #(
   parameter int DIV        = 256,
   parameter int LOG2_RATIO = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] in,
   output logic signed [15:0] out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               overrun
);

   localparam int AW = 16 + LOG2_RATIO;
   // phase keeps one bit when LOG2_RATIO is 0 so every tick is the last one
   localparam int PW = (LOG2_RATIO > 0) ? LOG2_RATIO : 1;
   localparam logic [PW-1:0] LAST     = PW'((1 << LOG2_RATIO) - 1);
   localparam logic [9:0]    DIV_LAST = 10'(DIV - 1);

   function automatic logic signed [15:0] floor_avg(input logic signed [AW-1:0] s);
      return 16'(s >>> LOG2_RATIO);
   endfunction

   logic [9:0]           div_cnt;
   logic [PW-1:0]        phase;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] in_ext;
   logic signed [AW-1:0] sum;
   logic                 tick;
   logic                 new_result;

   assign in_ext     = AW'(in);
   assign sum        = acc + in_ext;
   assign tick       = (div_cnt == DIV_LAST);
   assign new_result = tick && (phase == LAST);

   // tick grid and accumulation stage
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         phase   <= '0;
         acc     <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 10'd1;
         if (tick) begin
            if (phase == LAST) begin
               phase <= '0;
               acc   <= '0;
            end else begin
               phase <= phase + PW'(1);
               acc   <= sum;
            end
         end
      end
   end

   // output register and mixer handshake stage
   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (new_result) begin
         out       <= floor_avg(sum);
         out_valid <= 1'b1;
         if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jailbreak_speech_decimator.sv
// Self-checking bench for jailbreak_speech_decimator: vector table, hand-written
// handshake/reset sequences, and randomized traffic against an averaging model.
module tb_jailbreak_speech_decimator;

   localparam int DIV = 256;
   localparam int L2  = 2;
   localparam int R   = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [15:0] in = '0;
   logic               out_ready = 1'b0;
   logic signed [15:0] out;
   logic               out_valid;
   logic               overrun;

   int checks = 0;
   int errors = 0;

   jailbreak_speech_decimator #(.DIV(DIV), .LOG2_RATIO(L2)) dut (
      .clk(clk),
      .reset(reset),
      .in(in),
      .out(out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [15:0] s0;
      logic signed [15:0] s1;
      logic signed [15:0] s2;
      logic signed [15:0] s3;
      logic signed [15:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic window(input logic signed [15:0] v);
      in = v;
      repeat (DIV) step();
   endtask

   // floor(sum / R) computed with plain integer arithmetic
   function automatic int floor_div(input int sum);
      int q;
      q = sum / R;
      if (sum < 0 && q * R != sum) q = q - 1;
      return q;
   endfunction

   initial begin
      int q[$];
      int sum;
      logic signed [15:0] mo;
      logic mv, mov, newres;

      vecs[0] = '{1000, 1000, 1000, 1000, 1000};
      vecs[1] = '{0, 1, 2, 3, 1};
      vecs[2] = '{-1, -1, -1, -1, -1};
      vecs[3] = '{-1, 0, 0, 0, -1};
      vecs[4] = '{32767, 32767, 32767, 32767, 32767};
      vecs[5] = '{-32768, -32768, -32768, -32768, -32768};
      vecs[6] = '{32767, -32768, 32767, -32768, -1};
      vecs[7] = '{-5, 0, 0, 0, -2};
      vecs[8] = '{3, 0, 0, 0, 0};
      vecs[9] = '{100, 200, 300, 401, 250};

      do_reset();
      chk("reset_out", out, 0);
      chk("reset_valid", {31'b0, out_valid}, 0);
      chk("reset_overrun", {31'b0, overrun}, 0);

      // table-driven averages with the mixer always ready
      for (int i = 0; i < 10; i++) begin
         do_reset();
         out_ready = 1'b1;
         window(vecs[i].s0);
         window(vecs[i].s1);
         window(vecs[i].s2);
         window(vecs[i].s3);
         chk($sformatf("vec%0d_out", i), out, vecs[i].exp);
         chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 1);
         chk($sformatf("vec%0d_overrun", i), {31'b0, overrun}, 0);
         step();
         chk($sformatf("vec%0d_pulse", i), {31'b0, out_valid}, 0);
      end

      // second result period with constant input
      do_reset();
      out_ready = 1'b1;
      in = 1000;
      repeat (1023) step();
      chk("const_pre_valid", {31'b0, out_valid}, 0);
      step();
      chk("const_first_valid", {31'b0, out_valid}, 1);
      repeat (1023) step();
      chk("const_gap_valid", {31'b0, out_valid}, 0);
      step();
      chk("const_second_valid", {31'b0, out_valid}, 1);
      chk("const_second_out", out, 1000);

      // backpressure across two result edges, then a single accept
      do_reset();
      out_ready = 1'b0;
      repeat (4) window(10);
      chk("bp_first_out", out, 10);
      chk("bp_first_overrun", {31'b0, overrun}, 0);
      repeat (4) window(20);
      chk("bp_second_out", out, 20);
      chk("bp_second_valid", {31'b0, out_valid}, 1);
      chk("bp_overrun", {31'b0, overrun}, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_accept_valid", {31'b0, out_valid}, 0);
      chk("bp_accept_overrun", {31'b0, overrun}, 1);
      chk("bp_accept_out", out, 20);

      // reset mid-accumulation clears overrun/out and discards the partial sum
      in = 5000;
      repeat (600) step();
      reset = 1'b1;
      step();
      chk("mr_out", out, 0);
      chk("mr_valid", {31'b0, out_valid}, 0);
      chk("mr_overrun", {31'b0, overrun}, 0);
      reset = 1'b0;
      in = 100;
      repeat (1023) step();
      chk("mr_early_valid", {31'b0, out_valid}, 0);
      step();
      chk("mr_first_valid", {31'b0, out_valid}, 1);
      chk("mr_first_out", out, 100);

      // accept coinciding with a new result
      do_reset();
      in = 7;
      repeat (1024) step();
      chk("sim_first_out", out, 7);
      in = 9;
      repeat (1023) step();
      chk("sim_hold_valid", {31'b0, out_valid}, 1);
      chk("sim_hold_out", out, 7);
      out_ready = 1'b1;
      step();
      chk("sim_valid", {31'b0, out_valid}, 1);
      chk("sim_out", out, 9);
      chk("sim_overrun", {31'b0, overrun}, 0);
      step();
      out_ready = 1'b0;
      chk("sim_after_valid", {31'b0, out_valid}, 0);

      // randomized traffic against the averaging model
      do_reset();
      q.delete();
      mv = 1'b0;
      mov = 1'b0;
      mo = '0;
      for (int c = 0; c < 32 * DIV; c++) begin
         if (c % DIV == 0) in = 16'($urandom);
         if (c < 16 * DIV) out_ready = ($urandom_range(0, 3) == 0);
         else out_ready = ($urandom_range(0, 1999) == 0);
         newres = 1'b0;
         if ((c + 1) % DIV == 0) begin
            q.push_back(int'(in));
            if (q.size() == R) begin
               sum = 0;
               foreach (q[k]) sum += q[k];
               mo = 16'(floor_div(sum));
               q.delete();
               newres = 1'b1;
            end
         end
         if (newres) begin
            if (mv && !out_ready) mov = 1'b1;
            mv = 1'b1;
         end else if (mv && out_ready) begin
            mv = 1'b0;
         end
         step();
         chk("rnd_valid", {31'b0, out_valid}, {31'b0, mv});
         chk("rnd_overrun", {31'b0, overrun}, {31'b0, mov});
         if (mv) chk("rnd_out", out, mo);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
